// File: rtl/cic_pkg.sv
// Shared constants, types and width helper for the CIC decimator
// (cic_decimator, cic_comb_stage).
package cic_pkg;

  localparam int CIC_N_STAGES_DEF = 3;
  localparam int CIC_R_DEF        = 8;
  localparam int CIC_IN_W_DEF     = 8;
  localparam int CIC_OUT_W_DEF    = 8;
  localparam int CIC_MAX_STAGES   = 6;

  // Bit 0 is the capture-stage valid, bit k+1 the valid of comb stage k.
  typedef logic [CIC_MAX_STAGES:0] comb_valid_t;

  // Bit growth of an N-stage, M=1 CIC is N*log2(R) on top of the input width.
  function automatic int cic_acc_w(input int in_w, input int n, input int r);
    return in_w + n * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One M=1 comb section: y = x - x_prev at the decimated rate, with valid pass-through.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = cic_acc_w(CIC_IN_W_DEF, CIC_N_STAGES_DEF, CIC_R_DEF)
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                in_valid,
  input  logic signed [W-1:0] x,
  output logic                out_valid,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] delay;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      y         <= '0;
      delay     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y     <= x - delay;
        delay <= x;
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M=1). Define CIC_ROUND_EN for round-half-up output
// scaling with positive saturation; otherwise the output is floor-truncated.
module cic_decimator
  import cic_pkg::*;
#(
  parameter  int N_STAGES = CIC_N_STAGES_DEF,
  parameter  int R        = CIC_R_DEF,
  parameter  int IN_W     = CIC_IN_W_DEF,
  parameter  int OUT_W    = CIC_OUT_W_DEF,
  localparam int ACC_W    = cic_acc_w(IN_W, N_STAGES, R)
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  din,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic signed [ACC_W-1:0] dout_full
);

  localparam int          PH_W      = $clog2(R);
  localparam int          SH        = ACC_W - OUT_W;
  localparam comb_valid_t LAST_MASK = comb_valid_t'(1) << N_STAGES;

  logic [PH_W-1:0]         phase;
  logic                    strobe;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] integ [N_STAGES];
  logic signed [ACC_W-1:0] cap_data;
  logic                    cap_valid;
  logic signed [ACC_W-1:0] comb_data [N_STAGES+1];
  comb_valid_t             valid_chain;

  // R is a power of two, so the last phase is all ones and phase wraps for free.
  assign strobe  = in_valid && (&phase);
  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

  always_ff @(posedge clock) begin
    if (!nreset) begin
      // NOTE: the integrator array is state, not storage; leaving it unreset
      // would let stale sums leak into the first outputs after reset.
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
      phase     <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= strobe;
      if (strobe) cap_data <= integ[N_STAGES-1];
      if (in_valid) begin
        phase    <= phase + 1'b1;
        // NOTE: non-blocking updates make every right-hand integ[k-1] its
        // pre-update value, which is exactly the cascade behaviour wanted.
        integ[0] <= integ[0] + din_ext;
        for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  assign comb_data[0]   = cap_data;
  assign valid_chain[0] = cap_valid;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clock     (clock),
      .nreset    (nreset),
      .in_valid  (valid_chain[k]),
      .x         (comb_data[k]),
      .out_valid (valid_chain[k+1]),
      .y         (comb_data[k+1])
    );
  end

  if (N_STAGES < CIC_MAX_STAGES) begin : g_valid_pad
    assign valid_chain[CIC_MAX_STAGES:N_STAGES+1] = '0;
  end

  assign out_valid = |(valid_chain & LAST_MASK);
  // The last comb only updates on its valid, so both outputs hold between pulses.
  assign dout_full = comb_data[N_STAGES];

`ifdef CIC_ROUND_EN
  if (SH == 0) begin : g_round_none
    assign dout = OUT_W'(dout_full);
  end else begin : g_round
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(64'sd1 <<< (SH-1));
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);

    logic signed [ACC_W:0] rnd_sum;
    logic signed [ACC_W:0] rnd_shift;

    always_comb begin
      // NOTE: every path assigns dout, so no latch is inferred.
      rnd_sum   = {dout_full[ACC_W-1], dout_full} + HALF;
      rnd_shift = rnd_sum >>> SH;
      dout      = rnd_shift[OUT_W-1:0];
      if (rnd_shift > OUT_MAX) dout = OUT_MAX[OUT_W-1:0];
    end
  end
`else
  assign dout = OUT_W'(dout_full >>> SH);
`endif

endmodule
